// File: rtl/soi_access_if.sv
// Requester-side bus of the SOI access arbiter: level requests with per-requester
// command slices going in, one-hot grant and a single shared response coming back.
interface soi_access_if #(
   parameter int N_REQ  = 4,
   parameter int ADDR_W = 3,
   parameter int DATA_W = 8
) ();
   localparam int ID_W = $clog2(N_REQ);

   logic [N_REQ-1:0]        req;
   logic [N_REQ-1:0]        we;
   logic [N_REQ*ADDR_W-1:0] addr;
   logic [N_REQ*DATA_W-1:0] wdata;
   logic [N_REQ-1:0]        gnt;
   logic                    rsp_valid;
   logic [ID_W-1:0]         rsp_id;
   logic [DATA_W-1:0]       rsp_data;
   logic                    rsp_err;

   modport master (
      output req, we, addr, wdata,
      input  gnt, rsp_valid, rsp_id, rsp_data, rsp_err
   );

   modport slave (
      input  req, we, addr, wdata,
      output gnt, rsp_valid, rsp_id, rsp_data, rsp_err
   );
endinterface

// File: rtl/soi_access_arbiter.sv
// Round-robin arbiter owning a bank of SOI registers; each grant performs one
// read or write, and reg0 bit0 can run as a free-toggling heartbeat.
module soi_access_arbiter #(
   parameter int                N_REQ     = 4,
   parameter int                NUM_REGS  = 8,
   parameter int                ADDR_W    = 3,
   parameter int                DATA_W    = 8,
   parameter logic [DATA_W-1:0] RESET_VAL = {{(DATA_W-1){1'b0}}, 1'b1}
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_toggle_en,
   soi_access_if.slave                bus,
   output logic [NUM_REGS*DATA_W-1:0] o_soi_flat
);
   localparam int                ID_W        = $clog2(N_REQ);
   localparam logic [ADDR_W:0]   LP_NUM_REGS = (ADDR_W+1)'(NUM_REGS);
   localparam logic [ID_W-1:0]   LP_LAST_ID  = ID_W'(N_REQ - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_EXEC  = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ID_W-1:0]     r_rr_ptr;
   logic [ID_W-1:0]     w_win_id;
   logic                w_any_req;
   logic                w_accept;
   logic [N_REQ-1:0]    w_gnt;

   logic [ID_W-1:0]     r_id;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;

   logic                w_exec;
   logic                w_addr_ok;
   logic                w_wr;
   logic [DATA_W-1:0]   w_rd_data;

   logic                r_rsp_valid;
   logic [ID_W-1:0]     r_rsp_id;
   logic [DATA_W-1:0]   r_rsp_data;
   logic                r_rsp_err;

   logic [DATA_W-1:0]   r_regs [NUM_REGS];

   // First requesting index at or after rr_ptr, wrapping past N_REQ-1.
   always_comb begin
      w_any_req = 1'b0;
      w_win_id  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!w_any_req && bus.req[(int'(r_rr_ptr) + k) % N_REQ]) begin
            w_any_req = 1'b1;
            w_win_id  = ID_W'((int'(r_rr_ptr) + k) % N_REQ);
         end
      end
   end

   assign w_accept = (r_state == S_IDLE) && w_any_req;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_gnt       = '0;
      case (r_state)
         S_IDLE: begin
            if (w_any_req) begin
               w_state_nxt = S_GRANT;
            end
         end
         S_GRANT: begin
            w_gnt[r_id] = 1'b1;
            w_state_nxt = S_EXEC;
         end
         S_EXEC: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr <= '0;
      end else if (w_accept) begin
         r_rr_ptr <= (w_win_id == LP_LAST_ID) ? '0 : w_win_id + ID_W'(1);
      end
   end

   // The winner's command is captured once, so a later req drop cannot cancel it.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_id    <= w_win_id;
         r_we    <= bus.we[w_win_id];
         r_addr  <= bus.addr[w_win_id*ADDR_W +: ADDR_W];
         r_wdata <= bus.wdata[w_win_id*DATA_W +: DATA_W];
      end
   end

   assign w_exec    = (r_state == S_EXEC);
   assign w_addr_ok = ({1'b0, r_addr} < LP_NUM_REGS);
   assign w_wr      = w_exec && r_we && w_addr_ok;
   assign w_rd_data = (w_addr_ok && !r_we) ? r_regs[r_addr] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= '0;
         r_rsp_data  <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_rsp_valid <= w_exec;
         r_rsp_id    <= w_exec ? r_id : '0;
         r_rsp_data  <= w_exec ? w_rd_data : '0;
         r_rsp_err   <= w_exec && !w_addr_ok;
      end
   end

   // The write is issued after the heartbeat so a same-edge write to reg0 wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= RESET_VAL;
         end
      end else begin
         if (i_toggle_en) begin
            r_regs[0][0] <= ~r_regs[0][0];
         end
         if (w_wr) begin
            r_regs[r_addr] <= r_wdata;
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign o_soi_flat[g*DATA_W +: DATA_W] = r_regs[g];
   end

   assign bus.gnt       = w_gnt;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_id    = r_rsp_id;
   assign bus.rsp_data  = r_rsp_data;
   assign bus.rsp_err   = r_rsp_err;
endmodule
